frame_compositor: RTL
=====================

# frame_compositor

Builds one 240x160 frame per request. For each pixel it reads the scrolled window of the gym map RAM and the current player sprite from the character RAM, overlays the sprite using the magenta transparency key, and writes the 24-bit result into the framebuffer RAM. It sits between the map/character RAMs and the framebuffer RAM; the VGA scan-out reads the framebuffer independently.

## Interface
- FB_W, 240: frame width in pixels
- FB_H, 160: frame height in pixels
- MAP_W, 464: gym map width in pixels (map RAM is MAP_W*MAP_H = 180032 entries)
- MAP_H, 388: gym map height in pixels
- SHEET_W, 112: character sheet width in pixels
- SPR_W, 16: sprite width
- SPR_H, 20: sprite height
- SPR_X, 112: sprite screen column (left edge)
- SPR_Y, 70: sprite screen row (top edge)
- KEY, 24'hFF00FF: transparent colour

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to compose a frame
- scroll_x  in  9  map column of the frame's left edge
- scroll_y  in  9  map row of the frame's top edge
- frame_x  in  7  sheet column of the sprite's top-left corner
- frame_y  in  8  sheet row of the sprite's top-left corner
- busy  out  1  high while composing
- done  out  1  one-cycle pulse after the last framebuffer write
- map_addr  out  19  gym map RAM read address
- map_data  in  24  decoded map pixel, valid 1 cycle after map_addr
- chr_addr  out  19  character RAM read address
- chr_data  in  24  sprite pixel, valid 1 cycle after chr_addr
- fb_addr  out  19  framebuffer write address
- fb_data  out  24  framebuffer write data
- fb_we  out  1  framebuffer write enable

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: when start=1, latch scroll_x, scroll_y, frame_x and frame_y, clear x and y, and go to RUN.
  - Latched scroll values are clamped: scroll_x to at most MAP_W-FB_W (224), scroll_y to at most MAP_H-FB_H (228).
- RUN: one pixel per cycle, raster order (x fastest).
  - map_addr = (sy+y)*MAP_W + (sx+x).
  - in_spr = (x-SPR_X) < SPR_W and (y-SPR_Y) < SPR_H, unsigned.
  - chr_addr = (fy + y - SPR_Y)*SHEET_W + (fx + x - SPR_X) when in_spr, else 0.
  - x wraps at FB_W-1 to 0 and increments y. At x=FB_W-1, y=FB_H-1, go to FLUSH.
- Stage 1 (one cycle after issue): the pixel address and in_spr are delayed one cycle.
  - fb_data = chr_data if in_spr_d and chr_data != KEY, else map_data.
  - fb_addr = y_d*FB_W + x_d. fb_we=1.
- FLUSH: performs the final stage-1 write, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while not IDLE is ignored. Inputs changing mid-frame have no effect.
- All address arithmetic is unsigned, computed at ≥19 bits, with no truncation before the final 19-bit result.

## Timing
- Reset values: busy=0, done=0, fb_we=0, map_addr=0, chr_addr=0, fb_addr=0, fb_data=0. State=IDLE.
- Reset asserted mid-frame: outputs return to reset values immediately, with no further fb writes. The partial frame remains in the framebuffer.
- busy rises the cycle after start is sampled and falls in the same cycle done pulses.
- The first fb_we occurs 2 cycles after start is sampled. Exactly FB_W*FB_H (38400) consecutive fb_we cycles follow.
- done occurs on the cycle after the last fb_we. Start to done is 38402 cycles.
- The RAM read latency is exactly 1 cycle. There is no backpressure.

## Structure
- A shared package `compositor_pkg` holds KEY, FB_W, FB_H, and the MAP_*, SHEET_W, SPR_* defaults, plus a state enum typedef `comp_state_t`.
- Sub-module `raster_counter`: x/y counter with enable, wrap, and last-pixel flag. The address pipeline stays in the top module.

## Test plan
- Compose with scroll=(0,0), map RAM model returning address as colour, and sprite all KEY. Required: fb[i] equals map colour for (x, y) = (i%240, i/240), for all 38400 writes, with done at cycle 38402.
- scroll=(500,400). Required: clamped to (224,228), so fb_addr 0 gets map_addr 228*464+224 = 106016.
- Sprite frame (16,20), sprite pixel at sheet (16,20) = 24'h123456. Required: fb_addr 70*240+112 = 16912 gets 24'h123456. Sprite KEY pixels show the map colour. Pixel (111,70) is map.
- start pulsed again during RUN, and inputs changed mid-frame. Required: no restart, output identical to an undisturbed frame, and a single done pulse.
- Reset_n asserted at cycle 1000 of a frame. Required: fb_we=0 and busy=0 in the same cycle. A subsequent start produces a complete, correct frame.
- Back-to-back frames, with start on the cycle after done. Required: the second frame begins 2 cycles later and no fb write is dropped or duplicated.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared constants, widths and state type for the frame compositor.
package compositor_pkg;

  localparam int unsigned FB_W    = 240;
  localparam int unsigned FB_H    = 160;
  localparam int unsigned MAP_W   = 464;
  localparam int unsigned MAP_H   = 388;
  localparam int unsigned SHEET_W = 112;
  localparam int unsigned SPR_W   = 16;
  localparam int unsigned SPR_H   = 20;
  localparam int unsigned SPR_X   = 112;
  localparam int unsigned SPR_Y   = 70;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 24;
  localparam int unsigned XW  = 8;
  localparam int unsigned YW  = 8;
  localparam int unsigned SXW = 9;
  localparam int unsigned SYW = 9;
  localparam int unsigned FXW = 7;
  localparam int unsigned FYW = 8;

  localparam int unsigned SX_MAX = MAP_W - FB_W;
  localparam int unsigned SY_MAX = MAP_H - FB_H;

  localparam logic [DW-1:0] KEY = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } comp_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter with clear, enable, wrap and last-pixel flag.
module raster_counter
  import compositor_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [XW-1:0] o_next_x_c,
  output logic [YW-1:0] o_next_y_c,
  output logic          o_last_c
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end  = (r_x == XW'(FB_W - 1));
  assign w_y_end  = (r_y == YW'(FB_H - 1));
  assign o_last_c = w_x_end & w_y_end;

  // Next position is exported so the top can issue addresses one step ahead.
  always_comb begin
    o_next_x_c = r_x + XW'(1);
    o_next_y_c = r_y;
    if (w_x_end) begin
      o_next_x_c = '0;
      o_next_y_c = w_y_end ? '0 : r_y + YW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      r_x <= o_next_x_c;
      r_y <= o_next_y_c;
    end
  end

endmodule

// File: rtl/frame_compositor.sv
// Composes one scrolled map window with a keyed sprite overlay into the framebuffer.
module frame_compositor
  import compositor_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [SXW-1:0] scroll_x,
  input  logic [SYW-1:0] scroll_y,
  input  logic [FXW-1:0] frame_x,
  input  logic [FYW-1:0] frame_y,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  map_addr,
  input  logic [DW-1:0]  map_data,
  output logic [AW-1:0]  chr_addr,
  input  logic [DW-1:0]  chr_data,
  output logic [AW-1:0]  fb_addr,
  output logic [DW-1:0]  fb_data,
  output logic           fb_we
);

  comp_state_t    r_state;
  comp_state_t    w_state_nxt;
  logic           w_clr;
  logic           w_adv;
  logic           w_issue;
  logic           w_last;
  logic [XW-1:0]  w_next_x;
  logic [YW-1:0]  w_next_y;

  logic [SXW-1:0] r_sx;
  logic [SYW-1:0] r_sy;
  logic [FXW-1:0] r_fx;
  logic [FYW-1:0] r_fy;
  logic [SXW-1:0] w_sx;
  logic [SYW-1:0] w_sy;
  logic [FXW-1:0] w_fx;
  logic [FYW-1:0] w_fy;

  logic [XW-1:0]  w_px;
  logic [YW-1:0]  w_py;
  logic [AW-1:0]  w_dx;
  logic [AW-1:0]  w_dy;
  logic           w_in_spr;
  logic [AW-1:0]  w_map_addr;
  logic [AW-1:0]  w_chr_addr;
  logic [AW-1:0]  w_pix;

  logic           r_iss_v;
  logic           r_in_spr;
  logic [AW-1:0]  r_pix;
  logic           r_s1_v;
  logic           r_s1_spr;
  logic [AW-1:0]  r_s1_pix;

  raster_counter u_raster (
    .i_clk      (Clk),
    .i_rst_n    (Reset_n),
    .i_clr      (w_clr),
    .i_en       (w_adv),
    .o_next_x_c (w_next_x),
    .o_next_y_c (w_next_y),
    .o_last_c   (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = FLUSH;
        end else begin
          w_adv = 1'b1;
        end
      end
      FLUSH:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_issue = w_clr | w_adv;

  // The start cycle issues pixel (0,0) straight from the clamped inputs.
  always_comb begin
    w_sx = r_sx;
    w_sy = r_sy;
    w_fx = r_fx;
    w_fy = r_fy;
    if (r_state == IDLE) begin
      w_sx = (scroll_x > SXW'(SX_MAX)) ? SXW'(SX_MAX) : scroll_x;
      w_sy = (scroll_y > SYW'(SY_MAX)) ? SYW'(SY_MAX) : scroll_y;
      w_fx = frame_x;
      w_fy = frame_y;
    end
  end

  assign w_px = w_clr ? '0 : w_next_x;
  assign w_py = w_clr ? '0 : w_next_y;

  // Unsigned offset compare rejects pixels left of / above the sprite too.
  assign w_dx       = AW'(w_px) - AW'(SPR_X);
  assign w_dy       = AW'(w_py) - AW'(SPR_Y);
  assign w_in_spr   = (w_dx < AW'(SPR_W)) && (w_dy < AW'(SPR_H));
  assign w_map_addr = (AW'(w_sy) + AW'(w_py)) * AW'(MAP_W) + AW'(w_sx) + AW'(w_px);
  assign w_chr_addr = w_in_spr ? ((AW'(w_fy) + w_dy) * AW'(SHEET_W) + AW'(w_fx) + w_dx) : '0;
  assign w_pix      = AW'(w_py) * AW'(FB_W) + AW'(w_px);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_fx     <= '0;
      r_fy     <= '0;
      map_addr <= '0;
      chr_addr <= '0;
      r_pix    <= '0;
      r_in_spr <= 1'b0;
      r_iss_v  <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s1_spr <= 1'b0;
      r_s1_pix <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != IDLE);
      done    <= (r_state == DONE);
      if (w_clr) begin
        r_sx <= w_sx;
        r_sy <= w_sy;
        r_fx <= w_fx;
        r_fy <= w_fy;
      end
      if (w_issue) begin
        map_addr <= w_map_addr;
        chr_addr <= w_chr_addr;
        r_pix    <= w_pix;
        r_in_spr <= w_in_spr;
      end
      r_iss_v  <= w_issue;
      r_s1_v   <= r_iss_v;
      r_s1_spr <= r_in_spr;
      r_s1_pix <= r_pix;
      // RAM data for the stage-1 pixel is valid now; merge and write.
      fb_we <= r_s1_v;
      if (r_s1_v) begin
        fb_addr <= r_s1_pix;
        fb_data <= (r_s1_spr && (chr_data != KEY)) ? chr_data : map_data;
      end
    end
  end

endmodule
